// File: rtl/oam_dma_if.sv
// CPU-side and memory-map-side bus signals seen by the sprite DMA engine.
// The master modport is the DMA engine; the slave modport is the surrounding system.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_R_nW;
    logic [7:0]  mem_data_in;
    logic [15:0] Addr_bus;
    logic [7:0]  Data_bus_out;
    logic        R_nW;
    logic        rdy;
    logic        dma_active;

    modport master (
        input  cpu_addr, cpu_data_out, cpu_R_nW, mem_data_in,
        output Addr_bus, Data_bus_out, R_nW, rdy, dma_active
    );

    modport slave (
        output cpu_addr, cpu_data_out, cpu_R_nW, mem_data_in,
        input  Addr_bus, Data_bus_out, R_nW, rdy, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to DMA_REG_ADDR stalls the CPU and copies one
// 256-byte page to the OAM data port as read/write pairs.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic      clk_ph1,
    input  logic      rst,
    oam_dma_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] page;
    logic [7:0] page_next;
    logic [7:0] idx;
    logic [7:0] idx_next;
    logic [7:0] data_latch;
    logic [7:0] data_latch_next;
    logic       cycle_odd;

    logic       trigger;

    assign trigger = (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_R_nW;

    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            page       <= '0;
            idx        <= '0;
            data_latch <= '0;
            cycle_odd  <= 1'b0;
        end else begin
            state      <= state_next;
            page       <= page_next;
            idx        <= idx_next;
            data_latch <= data_latch_next;
            cycle_odd  <= ~cycle_odd;
        end
    end

    always_comb begin
        state_next      = state;
        page_next       = page;
        idx_next        = idx;
        data_latch_next = data_latch;

        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = HALT;
                    page_next  = bus.cpu_data_out;
                    idx_next   = '0;
                end
            end
            // The CPU only stops on a read cycle, so pending writes are let through.
            HALT: begin
                if (bus.cpu_R_nW) begin
                    state_next = cycle_odd ? ALIGN : READ;
                end
            end
            ALIGN: begin
                state_next = READ;
            end
            READ: begin
                state_next      = WRITE;
                data_latch_next = bus.mem_data_in;
            end
            WRITE: begin
                if (idx == 8'hff) begin
                    state_next = IDLE;
                end else begin
                    idx_next   = idx + 8'd1;
                    state_next = READ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.rdy          = (state == IDLE);
        bus.dma_active   = (state == READ) || (state == WRITE);
        bus.Addr_bus     = bus.cpu_addr;
        bus.Data_bus_out = bus.cpu_data_out;
        bus.R_nW         = bus.cpu_R_nW;

        if (state == READ) begin
            bus.Addr_bus     = {page, idx};
            bus.Data_bus_out = '0;
            bus.R_nW         = 1'b1;
        end else if (state == WRITE) begin
            bus.Addr_bus     = OAM_DATA_ADDR;
            bus.Data_bus_out = data_latch;
            bus.R_nW         = 1'b0;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a transfer-level model predicts every bus cycle
// (passthrough, stall, 256 read/write pairs) from page, CPU write count and parity.
module tb_oam_dma;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;
    int unsigned edges;

    oam_dma_if bus ();

    oam_dma #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) dut (
        .clk_ph1(clk),
        .rst    (rst),
        .bus    (bus.master)
    );

    // Memory map: every location returns its low address byte xor 5A.
    assign bus.mem_data_in = bus.Addr_bus[7:0] ^ 8'h5a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; its low bit is the expected cycle parity.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {5'd0, bus.rdy, bus.dma_active, bus.R_nW, bus.Addr_bus, bus.Data_bus_out};
    endfunction

    function automatic logic [31:0] expect_vec(input logic r, input logic a, input logic rw,
                                               input logic [15:0] ad, input logic [7:0] d);
        return {5'd0, r, a, rw, ad, d};
    endfunction

    function automatic logic [31:0] passthrough(input logic r);
        return expect_vec(r, 1'b0, bus.cpu_R_nW, bus.cpu_addr, bus.cpu_data_out);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
        bus.cpu_addr     = a;
        bus.cpu_data_out = d;
        bus.cpu_R_nW     = rw;
        #1;
    endtask

    // A random CPU cycle that is never a write to the trigger register.
    task automatic drive_random_safe(input logic force_read);
        logic [15:0] a;
        logic        rw;
        a  = 16'($urandom);
        rw = force_read ? 1'b1 : 1'($urandom);
        if (a == 16'h4014 && !rw) a = 16'h4015;
        drive(a, 8'($urandom), rw);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive_random_safe(1'b0);
            check("idle", observed(), passthrough(1'b1));
            next_cycle();
        end
    endtask

    // One complete transfer; abort_at >= 0 asserts reset during that WRITE.
    task automatic run_transfer(input logic [7:0] pg, input int nwr, input int want_odd,
                                input int abort_at);
        int unsigned stall;
        logic        odd;
        stall = 0;
        // Arrange for the HALT exit edge to see the requested parity.
        if (want_odd >= 0 && (((edges + 1 + nwr) % 2) != want_odd)) idle_cycles(1);

        drive(16'h4014, pg, 1'b0);
        check("trigger", observed(), passthrough(1'b1));
        next_cycle();

        for (int w = 0; w < nwr; w++) begin
            drive(16'($urandom), 8'($urandom), 1'b0);
            check("halt_wr", observed(), passthrough(1'b0));
            if (!bus.rdy) stall++;
            next_cycle();
        end
        drive_random_safe(1'b1);
        check("halt_rd", observed(), passthrough(1'b0));
        if (!bus.rdy) stall++;
        odd = edges[0];
        if (want_odd >= 0) check("parity", 32'(odd), 32'(want_odd));
        next_cycle();

        if (odd) begin
            drive_random_safe(1'b1);
            check("align", observed(), passthrough(1'b0));
            if (!bus.rdy) stall++;
            next_cycle();
        end

        for (int i = 0; i < 256; i++) begin
            // Occasional trigger writes while busy must be ignored.
            if ($urandom_range(0, 15) == 0) drive(16'h4014, 8'($urandom), 1'b0);
            else drive_random_safe(1'b0);
            check("read", observed(), expect_vec(1'b0, 1'b1, 1'b1, {pg, 8'(i)}, 8'h00));
            if (!bus.rdy) stall++;
            next_cycle();

            if ($urandom_range(0, 15) == 0) drive(16'h4014, 8'($urandom), 1'b0);
            else drive_random_safe(1'b0);
            check("write", observed(),
                  expect_vec(1'b0, 1'b1, 1'b0, 16'h2004, 8'(i) ^ 8'h5a));
            if (!bus.rdy) stall++;
            if (i == abort_at) begin
                #1 rst = 1'b1;
                #1;
                check("abort_out", observed(), passthrough(1'b1));
                next_cycle();
                check("abort_hold", observed(), passthrough(1'b1));
                rst = 1'b0;
                #1;
                return;
            end
            next_cycle();
        end

        drive_random_safe(1'b1);
        check("done", observed(), passthrough(1'b1));
        check("stall_len", 32'(stall), 32'(1 + nwr + int'(odd) + 512));
        idle_cycles(3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(16'h1234, 8'h77, 1'b1);
        check("reset_out", observed(), expect_vec(1'b1, 1'b0, 1'b1, 16'h1234, 8'h77));
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("reset_rel", observed(), expect_vec(1'b1, 1'b0, 1'b1, 16'h1234, 8'h77));
        next_cycle();
        check("reset_edge", observed(), expect_vec(1'b1, 1'b0, 1'b1, 16'h1234, 8'h77));

        // Non-triggers while idle.
        drive(16'h4014, 8'h09, 1'b1);
        check("rd_4014", observed(), passthrough(1'b1));
        next_cycle();
        drive(16'h4015, 8'h09, 1'b0);
        check("after_rd", observed(), passthrough(1'b1));
        next_cycle();
        check("after_4015", observed(), passthrough(1'b1));
        idle_cycles(2);

        run_transfer(8'h02, 0, 0, -1);
        run_transfer(8'h02, 0, 1, -1);
        run_transfer(8'hc7, 3, -1, -1);
        run_transfer(8'h55, 0, 0, 8'h40);
        idle_cycles(1);
        run_transfer(8'h03, 0, -1, -1);
        run_transfer(8'(($urandom_range(0, 254)) + 1), int'($urandom_range(0, 4)), -1, -1);
        run_transfer(8'hff, 1, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
